pulse_interval_meter: RTL and testbench

Measures the spacing between rising edges of a pulse train, in count_en-qualified cycles. It is the receive-side counterpart of the reloadable countdown timer. Fed that timer's out pulse and the same count_en, it reports the load interval the timer is running with. It is used for self-check of timer configurations and for measuring external tick sources.

---
 rtl/pulse_interval_meter_if.sv | 25 ++
 rtl/pulse_interval_meter.sv | 115 +++++++++++
 tb/tb_pulse_interval_meter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pulse_interval_meter_if.sv
// Control and result signals of the pulse interval meter.
// The bench drives through master; the meter uses slave.
interface pulse_interval_meter_if #(
  parameter int WIDTH = 9
);
  logic             start;
  logic             abort;
  logic             continuous;
  logic             count_en;
  logic             pulse_in;
  logic [WIDTH-1:0] interval;
  logic             valid;
  logic             overflow;
  logic             busy;

  modport master (
    output start, abort, continuous, count_en, pulse_in,
    input  interval, valid, overflow, busy
  );

  modport slave (
    input  start, abort, continuous, count_en, pulse_in,
    output interval, valid, overflow, busy
  );
endinterface

// File: rtl/pulse_interval_meter.sv
// Measures the spacing between rising edges of pulse_in in count_en-qualified
// cycles, with a saturating counter and single-shot or back-to-back modes.
module pulse_interval_meter #(
  parameter int WIDTH = 9
) (
  input logic                    clock,
  input logic                    reset,
  pulse_interval_meter_if.slave  bus
);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] counter, counter_nxt, count_inc;
  logic             sat, sat_nxt, sat_inc;
  logic             cont_mode, cont_nxt;
  logic             pulse_prev, edge_det;
  logic [WIDTH-1:0] interval_p1, interval_nxt;
  logic             ovf_p1, ovf_nxt;
  logic             vld_p1, vld_nxt;

  function automatic logic [WIDTH-1:0] sat_incr(input logic [WIDTH-1:0] v,
                                                input logic en);
    if (en && (v != CNT_MAX))
      return v + WIDTH'(1);
    return v;
  endfunction

  assign edge_det  = bus.pulse_in & ~pulse_prev;
  assign count_inc = sat_incr(counter, bus.count_en);
  // Reaching the maximum flags saturation even on an exact count.
  assign sat_inc   = sat | (count_inc == CNT_MAX);

  always_comb begin
    state_nxt    = state;
    counter_nxt  = counter;
    sat_nxt      = sat;
    cont_nxt     = cont_mode;
    interval_nxt = interval_p1;
    ovf_nxt      = ovf_p1;
    vld_nxt      = 1'b0;
    if (bus.abort) begin
      state_nxt   = IDLE;
      counter_nxt = '0;
      sat_nxt     = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state_nxt = ARMED;
            cont_nxt  = bus.continuous;
          end
        end
        ARMED: begin
          if (edge_det) begin
            state_nxt   = MEASURE;
            counter_nxt = '0;
            sat_nxt     = 1'b0;
          end
        end
        MEASURE: begin
          if (edge_det) begin
            interval_nxt = count_inc;
            ovf_nxt      = sat_inc;
            vld_nxt      = 1'b1;
            counter_nxt  = '0;
            sat_nxt      = 1'b0;
            if (!cont_mode)
              state_nxt = IDLE;
          end else begin
            counter_nxt = count_inc;
            sat_nxt     = sat_inc;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage p0: edge history, FSM state and running count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      counter    <= '0;
      sat        <= 1'b0;
      cont_mode  <= 1'b0;
      pulse_prev <= 1'b0;
    end else begin
      state      <= state_nxt;
      counter    <= counter_nxt;
      sat        <= sat_nxt;
      cont_mode  <= cont_nxt;
      pulse_prev <= bus.pulse_in;
    end
  end

  // Stage p1: captured result, held until the next capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      interval_p1 <= '0;
      ovf_p1      <= 1'b0;
      vld_p1      <= 1'b0;
    end else begin
      interval_p1 <= interval_nxt;
      ovf_p1      <= ovf_nxt;
      vld_p1      <= vld_nxt;
    end
  end

  assign bus.interval = interval_p1;
  assign bus.overflow = ovf_p1;
  assign bus.valid    = vld_p1;
  assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_pulse_interval_meter.sv
// Directed bench for pulse_interval_meter: expected captures are queued by
// the stimulus and consumed by a monitor whenever valid is seen.
module tb_pulse_interval_meter;
  localparam int WIDTH = 9;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;
  bit   alt   = 1'b0;

  typedef struct {
    int ival;
    int ovf;
  } exp_t;
  exp_t exp_q[$];

  pulse_interval_meter_if #(.WIDTH(WIDTH)) bus ();

  pulse_interval_meter #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every valid must match the oldest queued expectation.
  always @(negedge clock) begin
    if (reset && bus.valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("interval", int'(bus.interval), e.ival);
        chk("overflow", int'(bus.overflow), e.ovf);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      if (alt) bus.count_en = ~bus.count_en;
    end
  endtask

  // Rising edge now; next rising edge of the train is gap cycles later.
  task automatic pulse(input int w, input int gap);
    bus.pulse_in = 1'b1;
    cyc(w);
    bus.pulse_in = 1'b0;
    cyc(gap - w);
  endtask

  task automatic arm(input bit cont);
    bus.continuous = cont;
    bus.start      = 1'b1;
    cyc(1);
    bus.start      = 1'b0;
    bus.continuous = 1'b0;
  endtask

  task automatic push(input int ival, input int ovf);
    exp_t e;
    e.ival = ival;
    e.ovf  = ovf;
    exp_q.push_back(e);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.continuous = 1'b0;
    bus.count_en   = 1'b1;
    bus.pulse_in   = 1'b1;

    // Reset with pulse_in high
    cyc(3);
    chk("rst_interval", int'(bus.interval), 0);
    chk("rst_valid", int'(bus.valid), 0);
    chk("rst_overflow", int'(bus.overflow), 0);
    chk("rst_busy", int'(bus.busy), 0);
    reset = 1'b1;
    cyc(4);
    chk("post_rst_busy", int'(bus.busy), 0);
    bus.pulse_in = 1'b0;
    cyc(2);

    // Single shot, edges 7 apart
    arm(1'b0);
    cyc(2);
    push(7, 0);
    pulse(1, 7);
    pulse(1, 2);
    chk("single_busy", int'(bus.busy), 0);
    chk("single_hold", int'(bus.interval), 7);

    // Continuous, alternating count_en, wide pulses
    alt = 1'b1;
    arm(1'b1);
    cyc(2);
    push(10, 0);
    push(6, 0);
    pulse(4, 20);
    pulse(4, 12);
    pulse(4, 4);
    chk("cont_busy", int'(bus.busy), 1);
    bus.abort = 1'b1;
    cyc(1);
    bus.abort = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    alt = 1'b0;
    bus.count_en = 1'b1;
    cyc(2);

    // Saturation then a normal interval in continuous mode
    arm(1'b1);
    cyc(2);
    push(511, 1);
    push(20, 0);
    pulse(1, 600);
    pulse(1, 20);
    pulse(1, 2);
    bus.abort = 1'b1;
    cyc(1);
    bus.abort = 1'b0;
    cyc(2);

    // Abort mid-measurement, then a fresh 3-cycle measurement
    arm(1'b0);
    cyc(2);
    bus.pulse_in = 1'b1;
    cyc(1);
    bus.pulse_in = 1'b0;
    cyc(3);
    bus.abort = 1'b1;
    cyc(1);
    bus.abort = 1'b0;
    cyc(1);
    pulse(1, 4);
    chk("abort_idle", int'(bus.busy), 0);
    chk("abort_keep_interval", int'(bus.interval), 20);
    chk("abort_keep_overflow", int'(bus.overflow), 0);
    arm(1'b0);
    cyc(1);
    push(3, 0);
    pulse(1, 3);
    pulse(1, 3);
    chk("after_abort_interval", int'(bus.interval), 3);

    // Reset during MEASURE discards everything
    arm(1'b0);
    cyc(2);
    pulse(1, 3);
    reset = 1'b0;
    #1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_interval", int'(bus.interval), 0);
    cyc(2);
    reset = 1'b1;
    cyc(1);
    pulse(1, 4);
    chk("post_midrst_busy", int'(bus.busy), 0);

    // Edge coinciding with start is ignored
    bus.start    = 1'b1;
    bus.pulse_in = 1'b1;
    cyc(1);
    bus.start    = 1'b0;
    bus.pulse_in = 1'b0;
    chk("armed_busy", int'(bus.busy), 1);
    cyc(3);
    push(5, 0);
    pulse(1, 5);
    pulse(1, 3);
    chk("start_edge_interval", int'(bus.interval), 5);
    chk("start_edge_busy", int'(bus.busy), 0);

    cyc(5);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
